// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

  localparam logic [31:0] BasePcDefault = 32'h0040_0020;
  localparam int unsigned HdrBytes      = 2;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int unsigned IMEM_ADDR_W = 30
);

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   imem_we;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_wdata;

  // Host and memory side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/word_assembler.sv
// Collects a big-endian 32-bit word from four consecutive bytes.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The fourth byte is still on the input when the word is complete.
  assign word_o = {shift_q, byte_i};
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed word image from a byte stream into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 30,
  parameter logic [31:0] BASE_PC     = BasePcDefault
) (
  input  logic             clk,
  input  logic             start_up_n,
  input  logic             load_go,
  program_loader_if.slave  bus,
  output logic             cpu_start_up,
  output logic             load_done,
  output logic             load_err
);

  localparam logic [IMEM_ADDR_W-1:0] BaseWaddr  = IMEM_ADDR_W'(BASE_PC >> 2);
  localparam logic                   HdrLastIdx = 1'(HdrBytes - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e StAfterPayload = StCsum;
`else
  localparam loader_state_e StAfterPayload = StDone;
`endif

  loader_state_e          state_q, state_d;
  logic                   in_ready, accept, start;
  logic                   hdr_cnt_q, hdr_last;
  logic [7:0]             len_hi_q;
  logic [15:0]            len_word;
  logic [15:0]            words_left_q;
  logic                   imem_we_q;
  logic [IMEM_ADDR_W-1:0] addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            asm_word;
  logic                   asm_last;
  logic                   data_byte;

  // No byte is taken while a word is being written.
  assign in_ready  = (state_q inside {StLen, StData, StCsum}) && !imem_we_q;
  assign accept    = bus.in_valid && in_ready;
  assign start     = load_go && (state_q inside {StIdle, StDone, StErr});
  assign hdr_last  = (hdr_cnt_q == HdrLastIdx);
  assign len_word  = {len_hi_q, bus.in_data};
  assign data_byte = accept && (state_q == StData);

  word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_ni       (start_up_n),
    .clr_i        (start),
    .byte_valid_i (data_byte),
    .byte_i       (bus.in_data),
    .word_o       (asm_word),
    .last_o       (asm_last)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       csum_ok;

  assign csum_ok = (8'(sum_q + bus.in_data) == 8'd0);

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      sum_q <= '0;
    end else if (start) begin
      sum_q <= '0;
    end else if (accept && (state_q inside {StLen, StData})) begin
      sum_q <= sum_q + bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        if (accept && hdr_last) state_d = (len_word == 16'd0) ? StAfterPayload : StData;
      end
      StData: begin
        // Leave only once the final word's write strobe has been issued.
        if (imem_we_q && (words_left_q == 16'd0)) state_d = StAfterPayload;
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) state_d = csum_ok ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      hdr_cnt_q    <= 1'b0;
      len_hi_q     <= '0;
      words_left_q <= '0;
      imem_we_q    <= 1'b0;
      addr_q       <= BaseWaddr;
      wdata_q      <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (start) begin
        hdr_cnt_q <= 1'b0;
        addr_q    <= BaseWaddr;
      end
      // Address advances after each write and wraps naturally.
      if (imem_we_q) addr_q <= addr_q + IMEM_ADDR_W'(1);
      if (accept && (state_q == StLen)) begin
        len_hi_q  <= bus.in_data;
        hdr_cnt_q <= hdr_cnt_q + 1'b1;
        if (hdr_last) words_left_q <= len_word;
      end
      if (data_byte && asm_last) begin
        imem_we_q    <= 1'b1;
        wdata_q      <= asm_word;
        words_left_q <= words_left_q - 16'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign cpu_start_up = (state_q != StDone);
  assign load_done    = (state_q == StDone);
`ifdef LOADER_CHECKSUM_EN
  assign load_err     = (state_q == StErr);
`else
  assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized bench for program_loader with a word-level memory model.
module tb_program_loader;

  localparam int unsigned AW     = 30;
  localparam logic [31:0] BASE   = 32'h0040_0020;
  localparam int unsigned BASE_W = BASE >> 2;
  localparam int unsigned AMASK  = (1 << AW) - 1;

  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic start_up_n = 1'b0;
  logic load_go = 1'b0;
  logic cpu_start_up, load_done, load_err;

  program_loader_if #(.IMEM_ADDR_W(AW)) bus ();

  program_loader #(
    .IMEM_ADDR_W (AW),
    .BASE_PC     (BASE)
  ) dut (
    .clk          (clk),
    .start_up_n   (start_up_n),
    .load_go      (load_go),
    .bus          (bus),
    .cpu_start_up (cpu_start_up),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  logic [31:0] mem [int unsigned];
  logic prev_we = 1'b0;

  // Memory model plus write-strobe sanity on every write cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      mem[32'(bus.imem_addr)] = bus.imem_wdata;
      writes++;
      checks++;
      assert (bus.in_ready === 1'b0 && prev_we === 1'b0) else begin
        errors++;
        $error("FAIL we_cycle: observed in_ready=%b prev_we=%b required 0/0", bus.in_ready, prev_we);
      end
    end
    prev_we = bus.imem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic run_load(input word_q_t words, input int max_gap, input bit bad_csum,
                          input int go_at, input int bound);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [15:0] n16;
    int t;
    n16 = 16'(words.size());
    bytes.push_back(n16[15:8]);
    bytes.push_back(n16[7:0]);
    foreach (words[k]) begin
      bytes.push_back(words[k][31:24]);
      bytes.push_back(words[k][23:16]);
      bytes.push_back(words[k][15:8]);
      bytes.push_back(words[k][7:0]);
    end
    sum = 8'd0;
    foreach (bytes[i]) sum = sum + bytes[i];
`ifdef LOADER_CHECKSUM_EN
    bytes.push_back(8'(8'd0 - sum) + 8'(bad_csum));
`endif
    pulse_go();
    chk("go_hold_cpu", cpu_start_up, 1'b1);
    chk("go_clear_done", {load_done, load_err}, 2'b00);
    foreach (bytes[i]) begin
      if (i == go_at) pulse_go();
      send_byte(bytes[i], max_gap);
    end
    t = 0;
    while (!(load_done || load_err) && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!(load_done || load_err)) begin
      checks++;
      errors++;
      $error("FAIL finish_timeout: observed done=%b err=%b required a final state",
             load_done, load_err);
    end
  endtask

  task automatic check_mem(input string tag, input word_q_t words);
    int unsigned a;
    chk({tag, "_count"}, 64'(mem.num()), 64'(words.size()));
    foreach (words[k]) begin
      a = (BASE_W + k) & AMASK;
      chk({tag, "_word"}, mem.exists(a) ? mem[a] : 32'hxxxx_xxxx, words[k]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_we"}, bus.imem_we, 1'b0);
    chk({tag, "_addr"}, bus.imem_addr, 64'(BASE_W));
    chk({tag, "_wdata"}, bus.imem_wdata, 32'h0);
    chk({tag, "_cpu"}, cpu_start_up, 1'b1);
    chk({tag, "_flags"}, {load_done, load_err}, 2'b00);
  endtask

  initial begin
    word_q_t w, empty, ref_w;
    logic [31:0] snap [int unsigned];
    int n;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    start_up_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1'b0);

    // Two-word reference image.
    w = '{32'h2008_0005, 32'h2009_000A};
    mem.delete();
    writes = 0;
    run_load(w, 0, 1'b0, -1, 10);
    chk("basic_w0", mem.exists(32'h10_0008) ? mem[32'h10_0008] : 32'hx, 32'h2008_0005);
    chk("basic_w1", mem.exists(32'h10_0009) ? mem[32'h10_0009] : 32'hx, 32'h2009_000A);
    chk("basic_writes", 64'(writes), 64'd2);
    chk("basic_done", {load_done, load_err, cpu_start_up}, 3'b100);

    // Empty image: no writes, done promptly.
    mem.delete();
    writes = 0;
    run_load(empty, 0, 1'b0, -1, 3);
    chk("n0_writes", 64'(writes), 64'd0);
    chk("n0_done", {load_done, cpu_start_up}, 2'b10);

    // Same three words with and without bubbles.
    ref_w = '{$urandom, $urandom, $urandom};
    mem.delete();
    run_load(ref_w, 0, 1'b0, -1, 10);
    check_mem("nogap", ref_w);
    snap = mem;
    mem.delete();
    run_load(ref_w, 5, 1'b0, -1, 10);
    check_mem("gap", ref_w);
    for (int k = 0; k < 3; k++) begin
      chk("gap_vs_nogap", mem[(BASE_W + k) & AMASK], snap[(BASE_W + k) & AMASK]);
    end

    // load_go in the middle of the data phase is ignored.
    w = '{$urandom, $urandom};
    mem.delete();
    run_load(w, 1, 1'b0, 4, 10);
    check_mem("go_in_data", w);
    chk("go_in_data_done", {load_done, cpu_start_up}, 2'b10);

`ifdef LOADER_CHECKSUM_EN
    w = '{$urandom, $urandom};
    mem.delete();
    run_load(w, 0, 1'b1, -1, 10);
    chk("bad_csum", {load_done, load_err, cpu_start_up}, 3'b011);
    run_load(w, 0, 1'b0, -1, 10);
    chk("retry_csum", {load_done, load_err, cpu_start_up}, 3'b100);
`endif

    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(4, 1));
      w.delete();
      for (int k = 0; k < n; k++) w.push_back($urandom);
      mem.delete();
      run_load(w, int'($urandom_range(3, 0)), 1'b0, -1, 10);
      check_mem("rand", w);
    end

    // Abort mid-data: first word stays, partial second word never appears.
    w = '{32'hCAFE_0001, 32'hCAFE_0002};
    mem.delete();
    writes = 0;
    pulse_go();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(w[i / 4] >> (24 - 8 * (i % 4))), 0);
    start_up_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    chk("abort_writes", 64'(writes), 64'd1);
    chk("abort_w0", mem.exists(BASE_W) ? mem[BASE_W] : 32'hx, 32'hCAFE_0001);
    start_up_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter IMEM_ADDR_W, default 30, meaning the instruction-memory word-address width.
REQ-002 The module SHALL have parameter BASE_PC, default 32'h0040_0020, meaning the byte address of the first loaded word.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port start_up_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port load_go, input, 1 bit: one-cycle pulse that starts a load.
REQ-006 Port in_valid, input, 1 bit: host byte available.
REQ-007 Port in_data, input, 8 bits: host byte.
REQ-008 Port in_ready, output, 1 bit: loader accepts a byte when in_valid and in_ready are both high on a clk edge.
REQ-009 Port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 Port imem_addr, output, IMEM_ADDR_W bits: word address (byte address >> 2).
REQ-011 Port imem_wdata, output, 32 bits: instruction word.
REQ-012 Port cpu_start_up, output, 1 bit: active-high hold-reset driven to the processor start_up input.
REQ-013 Port load_done, output, 1 bit: level, high once a load completes successfully.
REQ-014 Port load_err, output, 1 bit: level, high once a load fails.

Function
REQ-015 The state machine SHALL have the states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-016 In IDLE, load_go SHALL move the state to LEN, clear load_done and load_err, and assert cpu_start_up.
REQ-017 In LEN, the loader SHALL accept 2 bytes forming a big-endian 16-bit word count N.
REQ-018 In DATA, the loader SHALL accept 4*N bytes, assembling each group of 4 bytes big-endian (first byte to bits [31:24]).
REQ-019 On acceptance of the 4th byte of word k, imem_we SHALL pulse high for exactly 1 cycle on the following cycle, with imem_addr = (BASE_PC>>2)+k and imem_wdata = the assembled word.
REQ-020 in_ready SHALL be high only in LEN, DATA and CSUM; it SHALL NOT be high in the cycle in which imem_we is high.
REQ-021 The word address SHALL wrap modulo 2^IMEM_ADDR_W without error.
REQ-022 If N = 0, the state SHALL go from LEN directly to CSUM (or to DONE when the checksum is compiled out), and no write SHALL occur.
REQ-023 From DATA, after the last write, the state SHALL go to CSUM, or to DONE when the checksum is compiled out.
REQ-024 In DONE, load_done SHALL be 1 and cpu_start_up SHALL deassert on the cycle DONE is entered.
REQ-025 In ERR, load_err SHALL be 1 and cpu_start_up SHALL remain 1.
REQ-026 DONE and ERR SHALL return to LEN on load_go.
REQ-027 load_go SHALL be ignored in LEN, DATA and CSUM.
REQ-028 Bubbles on in_valid SHALL stall the loader without loss of bytes.

Reset
REQ-029 While start_up_n is low, the state SHALL be IDLE, in_ready=0, imem_we=0, imem_addr=BASE_PC>>2, imem_wdata=0, cpu_start_up=1, load_done=0 and load_err=0.
REQ-030 Reset asserted mid-load SHALL abort immediately; words already written SHALL remain in memory, and no partial word SHALL be written.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined, the CSUM state SHALL accept 1 byte; DONE SHALL be entered if the 8-bit modulo-256 sum of all length and data bytes plus this byte equals 0, and ERR otherwise.
REQ-032 With LOADER_CHECKSUM_EN undefined, the CSUM state, the sum register and ERR entry SHALL be absent, and load_err SHALL be tied to 0.

Structure
REQ-033 The state enum, BASE_PC default and header byte count SHALL reside in shared package loader_pkg.
REQ-034 Sub-module word_assembler (byte shift register plus 2-bit byte counter) SHALL be instantiated once.

Verification
REQ-035 Reset: start_up_n=0 mid-DATA -> all outputs equal their reset values within the same cycle, and cpu_start_up=1.
REQ-036 Load N=2, words 0x20080005 and 0x2009000A, with the checksum correct -> writes to word addresses 0x100008 and 0x100009, then load_done=1 and cpu_start_up=0.
REQ-037 N=0, checksum byte 0x00 -> no imem_we pulse, DONE reached 3 cycles after the last byte.
REQ-038 Random in_valid gaps of 0-5 cycles during N=3 -> identical memory contents to the gap-free run.
REQ-039 Checksum byte wrong by 1 (checksum enabled) -> load_err=1, cpu_start_up held at 1; a following correct load_go load -> load_done=1 and load_err=0.
REQ-040 load_go pulsed during DATA -> ignored, the load completes normally.
